// File: rtl/logic16_arbiter.sv
// Shares one bitwise logic unit (AND/OR/XOR/NAND) among N_REQ requesters with a
// round-robin grant; define LOGIC16_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module logic16_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ID_W  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*WIDTH-1:0]   req_a_i,
  input  logic [N_REQ*WIDTH-1:0]   req_b_i,
  input  logic [N_REQ*2-1:0]       req_op_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o
);

  localparam int unsigned OP_W = 2;
  localparam logic [OP_W-1:0] OP_AND = 2'b00;
  localparam logic [OP_W-1:0] OP_OR  = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR = 2'b10;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [WIDTH-1:0]  a_g, b_g, result;
  logic [OP_W-1:0]   op_g;
  logic [WIDTH-1:0]  data_d;
  logic [ID_W-1:0]   id_d;

  // Rotating search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid_i[ID_W'(idx)]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  // Shared datapath on the granted requester's operands.
  always_comb begin
    a_g  = req_a_i[32'(gnt)*WIDTH +: WIDTH];
    b_g  = req_b_i[32'(gnt)*WIDTH +: WIDTH];
    op_g = req_op_i[32'(gnt)*OP_W +: OP_W];
    case (op_g)
      OP_AND:  result = a_g & b_g;
      OP_OR:   result = a_g | b_g;
      OP_XOR:  result = a_g ^ b_g;
      default: result = ~(a_g & b_g);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rsp_data_o <= '0;
      rsp_id_o   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_data_o <= data_d;
      rsp_id_o   <= id_d;
    end
  end

  // Next-state, handshake and result capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = rsp_data_o;
    id_d        = rsp_id_o;
    can_accept  = !rst_i && (state_q == IDLE || rsp_ready_i);
    accept      = can_accept && found;
    req_ready_o = accept ? (N_REQ'(1) << gnt) : '0;
    if (accept) begin
      state_d = RESP;
      data_d  = result;
      id_d    = gnt;
`ifdef LOGIC16_ARB_FIXED_PRIO_EN
      ptr_d   = '0;
`else
      ptr_d   = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
`endif
    end else if (state_q == RESP && rsp_ready_i) begin
      state_d = IDLE;
    end
  end

  assign rsp_valid_o = (state_q == RESP);

endmodule
